// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared constants and helpers for the sync_filt slice
package sync_pkg;

  localparam int SYNC_D_MIN     = 2;
  localparam int SYNC_D_MAX     = 8;
  localparam int STABLE_CYC_MIN = 1;
  localparam int STABLE_CYC_MAX = 255;

  // Stability counter must hold values 0..stable_cyc.
  function automatic int cnt_width(input int stable_cyc);
    return $clog2(stable_cyc + 1);
  endfunction

endpackage

// File: rtl/sync_filt_ch.sv
// rtl/sync_filt_ch.sv - one channel: synchronizer chain, stability filter, output register
module sync_filt_ch
  import sync_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int SYNC_D     = 3,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk_sync_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] unsync_data_i,
  input  logic              freeze_i,
  output logic [DATA_W-1:0] sync_data_o,
  output logic              upd_o,
  output logic              load_o
);

  localparam int                CNT_W   = cnt_width(STABLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  if (SYNC_D < SYNC_D_MIN || SYNC_D > SYNC_D_MAX) begin : g_bad_sync_d
    $error("sync_filt_ch: SYNC_D out of range");
  end
  if (STABLE_CYC < STABLE_CYC_MIN || STABLE_CYC > STABLE_CYC_MAX) begin : g_bad_stable_cyc
    $error("sync_filt_ch: STABLE_CYC out of range");
  end

  logic [DATA_W-1:0] r_sync [SYNC_D];
  logic [DATA_W-1:0] r_prev;
  logic [DATA_W-1:0] r_out;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_upd;

  logic [DATA_W-1:0] w_sample;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_load;

  assign w_sample = r_sync[SYNC_D-1];

  // Stability is judged on the count including this edge, so a held value loads without an extra cycle.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_sample != r_prev) begin
      w_cnt_nxt = CNT_ONE;
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
  end

  assign w_load = (w_cnt_nxt == CNT_MAX) && (w_sample != r_out) && !freeze_i;

  always_ff @(posedge clk_sync_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_D; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_upd  <= 1'b0;
    end else begin
      r_sync[0] <= unsync_data_i;
      for (int i = 1; i < SYNC_D; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_sample;
      r_cnt  <= w_cnt_nxt;
      if (w_load) begin
        r_out <= w_sample;
      end
      r_upd <= w_load;
    end
  end

  assign sync_data_o = r_out;
  assign upd_o       = r_upd;
  assign load_o      = w_load;

endmodule

// File: rtl/sync_filt.sv
// rtl/sync_filt.sv - multi-channel synchronizer with stability filter and update strobes
module sync_filt
  import sync_pkg::*;
#(
  parameter int ARRAY_W    = 9,
  parameter int DATA_W     = 12,
  parameter int SYNC_D     = 3,
  parameter int STABLE_CYC = 4
) (
  input  logic                           clk_sync_i,
  input  logic                           rst_i,
  input  logic [ARRAY_W-1:0][DATA_W-1:0] unsync_data_i,
  input  logic                           freeze_i,
  output logic [ARRAY_W-1:0][DATA_W-1:0] sync_data_o,
  output logic [ARRAY_W-1:0]             upd_o,
  output logic                           any_upd_o
);

  logic [ARRAY_W-1:0] w_load;
  logic               r_any_upd;

  for (genvar g = 0; g < ARRAY_W; g++) begin : g_ch
    sync_filt_ch #(
      .DATA_W     (DATA_W),
      .SYNC_D     (SYNC_D),
      .STABLE_CYC (STABLE_CYC)
    ) u_ch (
      .clk_sync_i    (clk_sync_i),
      .rst_i         (rst_i),
      .unsync_data_i (unsync_data_i[g]),
      .freeze_i      (freeze_i),
      .sync_data_o   (sync_data_o[g]),
      .upd_o         (upd_o[g]),
      .load_o        (w_load[g])
    );
  end

  // Reduce the per-channel load decisions so the OR lands in the same cycle as upd_o.
  always_ff @(posedge clk_sync_i or posedge rst_i) begin
    if (rst_i) begin
      r_any_upd <= 1'b0;
    end else begin
      r_any_upd <= |w_load;
    end
  end

  assign any_upd_o = r_any_upd;

endmodule

// File: tb/tb_sync_filt.sv
// tb/tb_sync_filt.sv - scoreboard bench for sync_filt with a run-length reference model
module tb_sync_filt;

  localparam int AW = 2;
  localparam int DW = 12;
  localparam int SD = 3;
  localparam int SC = 4;

  logic                   clk_sync_i = 1'b0;
  logic                   rst_i;
  logic [AW-1:0][DW-1:0]  unsync_data_i;
  logic                   freeze_i;
  logic [AW-1:0][DW-1:0]  sync_data_o;
  logic [AW-1:0]          upd_o;
  logic                   any_upd_o;

  sync_filt #(
    .ARRAY_W    (AW),
    .DATA_W     (DW),
    .SYNC_D     (SD),
    .STABLE_CYC (SC)
  ) dut (
    .clk_sync_i    (clk_sync_i),
    .rst_i         (rst_i),
    .unsync_data_i (unsync_data_i),
    .freeze_i      (freeze_i),
    .sync_data_o   (sync_data_o),
    .upd_o         (upd_o),
    .any_upd_o     (any_upd_o)
  );

  always #5 clk_sync_i = ~clk_sync_i;

  typedef struct packed {
    logic [AW-1:0][DW-1:0] data;
    logic [AW-1:0]         upd;
    logic                  any;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: inputs seen at each edge since reset, and per channel the run length of the value at the chain end.
  logic [AW-1:0][DW-1:0] in_hist[$];
  logic [DW-1:0]         m_out [AW];
  logic [DW-1:0]         m_last[AW];
  int                    m_run [AW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_edge();
    exp_t                  e;
    logic [AW-1:0][DW-1:0] old_in;
    logic [DW-1:0]         rd;
    e = '0;
    if (rst_i) begin
      in_hist.delete();
      for (int c = 0; c < AW; c++) begin
        m_out[c]  = '0;
        m_last[c] = '0;
        m_run[c]  = 0;
      end
    end else begin
      in_hist.push_back(unsync_data_i);
      old_in = '0;
      if (in_hist.size() > SD) old_in = in_hist[in_hist.size() - 1 - SD];
      for (int c = 0; c < AW; c++) begin
        rd        = old_in[c];
        m_run[c]  = (rd == m_last[c]) ? m_run[c] + 1 : 1;
        m_last[c] = rd;
        if (m_run[c] >= SC && rd != m_out[c] && !freeze_i) begin
          m_out[c]  = rd;
          e.upd[c]  = 1'b1;
        end
      end
    end
    for (int c = 0; c < AW; c++) e.data[c] = m_out[c];
    e.any = |e.upd;
    sb_q.push_back(e);
  endtask

  always @(negedge clk_sync_i) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sync_data_o", 64'(sync_data_o), 64'(e.data));
      check("upd_o", 64'(upd_o), 64'(e.upd));
      check("any_upd_o", 64'(any_upd_o), 64'(e.any));
    end
  end

  task automatic step(input logic r, input logic f, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    @(negedge clk_sync_i);
    #1;
    rst_i            = r;
    freeze_i         = f;
    unsync_data_i[0] = d0;
    unsync_data_i[1] = d1;
    @(posedge clk_sync_i);
    #1;
    model_edge();
  endtask

  int            first;
  int            strobes;
  logic [DW-1:0] cur0, cur1;
  logic          frz;

  initial begin
    rst_i         = 1'b1;
    freeze_i      = 1'b0;
    unsync_data_i = '0;

    step(1, 0, 0, 0);
    check("reset_state", {sync_data_o, upd_o, any_upd_o}, 64'd0);
    repeat (2) step(1, 0, 0, 0);

    // All-zero input after release: no strobe.
    strobes = 0;
    repeat (10) begin
      step(0, 0, 0, 0);
      if (upd_o != 0) strobes++;
    end
    check("zero_after_reset_no_strobe", strobes, 0);

    // Channel 0 step to 0x123 at edge 0.
    step(0, 0, 12'h123, 0);
    first = -1;
    for (int j = 1; j <= 12; j++) begin
      step(0, 0, 12'h123, 0);
      if (first < 0 && upd_o[0]) first = j;
    end
    check("latency_ch0", first, 6);
    check("ch0_value", 64'(sync_data_o[0]), 64'h123);

    // Channel 1 three-cycle glitch.
    strobes = 0;
    repeat (3) step(0, 0, 12'h123, 12'h0FF);
    repeat (12) begin
      step(0, 0, 12'h123, 0);
      if (upd_o[1]) strobes++;
    end
    check("glitch_no_strobe", strobes, 0);
    check("glitch_ch1_value", 64'(sync_data_o[1]), 64'h0);

    // Freeze over edges 0..20 while channel 0 moves to 0x055.
    strobes = 0;
    for (int j = 0; j <= 20; j++) begin
      step(0, 1, 12'h055, 0);
      if (upd_o != 0) strobes++;
    end
    check("freeze_no_strobe", strobes, 0);
    step(0, 0, 12'h055, 0);
    check("freeze_release_upd", 64'(upd_o), 64'h1);
    check("freeze_release_value", 64'(sync_data_o[0]), 64'h055);
    repeat (4) step(0, 0, 12'h055, 0);

    // Both channels change at edge 0.
    step(0, 0, 12'hAAA, 12'h555);
    first = -1;
    for (int j = 1; j <= 12; j++) begin
      step(0, 0, 12'hAAA, 12'h555);
      if (first < 0 && upd_o == 2'b11) first = j;
    end
    check("latency_both", first, 6);

    // Reset pulse at edge 4 of a 0x123 transfer.
    repeat (4) step(0, 0, 12'h123, 12'h555);
    step(1, 0, 12'h123, 12'h555);
    check("reset_mid_clear", {sync_data_o, upd_o, any_upd_o}, 64'd0);
    step(0, 0, 12'h123, 12'h555);
    first = -1;
    for (int j = 1; j <= 12; j++) begin
      step(0, 0, 12'h123, 12'h555);
      if (first < 0 && upd_o[0]) first = j;
    end
    check("latency_after_reset", first, 6);

    // Re-drive channel 0 to its current output after a short excursion.
    strobes = 0;
    repeat (2) step(0, 0, 12'h200, 12'h555);
    repeat (12) begin
      step(0, 0, 12'h123, 12'h555);
      if (upd_o[0]) strobes++;
    end
    check("redrive_no_strobe", strobes, 0);

    // Randomized traffic.
    cur0 = 12'h123;
    cur1 = 12'h555;
    frz  = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       cur0 = 12'h000;
          1:       cur0 = 12'h123;
          2:       cur0 = 12'hAAA;
          default: cur0 = 12'($urandom);
        endcase
      end
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       cur1 = 12'h000;
          1:       cur1 = 12'h555;
          2:       cur1 = 12'h0FF;
          default: cur1 = 12'($urandom);
        endcase
      end
      if ($urandom_range(0, 15) == 0) frz = ~frz;
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, frz, cur0, cur1);
    end

    @(negedge clk_sync_i);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_filt.md
SYNC_FILT -- requirements
Module: sync_filt

Interface
REQ-001 SHALL have parameter ARRAY_W, default 9, number of independent channels.
REQ-002 SHALL have parameter DATA_W, default 12, bits per channel.
REQ-003 SHALL have parameter SYNC_D, default 3, synchronizer flop depth; legal range 2..8.
REQ-004 SHALL have parameter STABLE_CYC, default 4, consecutive identical samples required before output update; legal range 1..255.
REQ-005 SHALL have port clk_sync_i, input, 1, destination clock; all state on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port unsync_data_i, input, ARRAY_W x DATA_W, asynchronous per-channel data.
REQ-008 SHALL have port freeze_i, input, 1, synchronous to clk_sync_i; blocks output loads while high.
REQ-009 SHALL have port sync_data_o, output, ARRAY_W x DATA_W, filtered synchronized data, registered.
REQ-010 SHALL have port upd_o, output, ARRAY_W, per-channel one-cycle update strobe, registered.
REQ-011 SHALL have port any_upd_o, output, 1, OR of upd_o, registered in the same cycle as upd_o.

Function
REQ-012 Each channel SHALL pass through a SYNC_D-deep flop chain; the last stage is the channel's sample.
REQ-013 Each channel SHALL hold a previous-sample register and a stability counter of width clog2(STABLE_CYC+1).
REQ-014 On an edge where the sample differs from the previous sample, the counter SHALL load 1; otherwise it SHALL increment, saturating at STABLE_CYC.
REQ-015 The previous-sample register SHALL load the sample on every edge.
REQ-016 A channel is stable when its counter equals STABLE_CYC; the counter counts the edges the current sample value has been present at the last stage.
REQ-017 On an edge where the channel is stable, the sample differs from sync_data_o, and freeze_i is low, sync_data_o SHALL load the sample and upd_o SHALL be 1 for the following cycle.
REQ-018 upd_o SHALL be 0 in every other cycle; a stable value equal to the current output SHALL produce no strobe.
REQ-019 Latency: an input value first sampled into stage 1 at edge n and then held SHALL appear on sync_data_o after edge n+SYNC_D+STABLE_CYC-1.
REQ-020 Any sample run shorter than STABLE_CYC edges SHALL never reach sync_data_o; it SHALL restart the counter.
REQ-021 While freeze_i is high, outputs SHALL hold, upd_o SHALL be 0, and synchronizer and counters SHALL keep running.
REQ-022 On the first edge with freeze_i low, a channel that is already stable with a differing value SHALL load immediately, so no extra delay.
REQ-023 Channels SHALL be fully independent; simultaneous updates on several channels SHALL set several upd_o bits in the same cycle.
REQ-024 With STABLE_CYC=1, the filter SHALL degenerate to one output register after the synchronizer.

Reset
REQ-025 On rst_i high, all sync stages, previous samples, counters, sync_data_o, upd_o and any_upd_o SHALL go to 0 asynchronously.
REQ-026 Reset release SHALL be synchronized externally; after release, an all-zero input SHALL produce no strobe.
REQ-027 Reset mid-filter SHALL discard any partial stability count.

Structure
REQ-028 Package sync_pkg SHALL hold a counter-width function and the legal-range constants for SYNC_D and STABLE_CYC.
REQ-029 The design SHALL use one sub-module, sync_filt_ch, containing one channel (chain, previous sample, counter, output register, strobe), generated ARRAY_W times.
REQ-030 The top-level SHALL contain only the generate loop and the any_upd_o OR-reduce register.
REQ-031 Parameters outside their legal range SHALL fail elaboration.

Verification (SYNC_D=3, STABLE_CYC=4, ARRAY_W=2, DATA_W=12)
REQ-032 Channel 0 steps from 0 to 0x123 at edge 0 and holds -> sync_data_o[0]=0x123 after edge 6, upd_o=01 for exactly one cycle, any_upd_o=1 in the same cycle.
REQ-033 Channel 1 has a 0x0FF glitch of 3 cycles, then returns to 0 -> sync_data_o[1] stays 0, upd_o never set.
REQ-034 freeze_i is high during edges 0..20 while channel 0 goes to 0x055 -> no update during the freeze; 0x055 loads on the first edge with freeze_i low.
REQ-035 Both channels change at edge 0, to 0xAAA and 0x555 -> both load after edge 6, upd_o=11 for one cycle.
REQ-036 rst_i pulses at edge 4 of a 0x123 transfer, then input holds -> outputs 0 during reset; 0x123 appears a full latency after release.
REQ-037 Channel 0 is re-driven to its current output value -> no strobe.
